// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL lock sequencer.
package pll_seq_pkg;

  localparam int STATE_W    = 2;
  localparam int LOSS_CNT_W = 8;

  typedef enum logic [STATE_W-1:0] {
    RST_HOLD  = 2'd0,
    WAIT_LOCK = 2'd1,
    RUN       = 2'd2,
    FAIL      = 2'd3
  } pll_state_e;

  // Saturating increment so the loss counter sticks at all-ones.
  function automatic logic [LOSS_CNT_W-1:0] loss_sat_inc(input logic [LOSS_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser, async active-low reset to 0.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// Holds the PLL in reset, waits for a stable lock with timeout/retry, then releases rst_out_n.
// Optional lock-loss counter is built only when PLL_SEQ_LOSS_CNT_EN is defined; otherwise lock_loss_cnt is 0.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_HOLD_CYCLES = 64,
  parameter int LOCK_TIMEOUT    = 65536,
  parameter int LOCK_STABLE     = 1024,
  parameter int MAX_RETRY       = 3,
  localparam int RETRY_W        = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic                  clkin,
  input  logic                  reset_n,
  input  logic                  pll_lock,
  input  logic                  restart,
  output logic                  pll_reset,
  output logic                  rst_out_n,
  output logic                  ready,
  output logic                  fail,
  output logic [RETRY_W-1:0]    retry_cnt,
  output logic [LOSS_CNT_W-1:0] lock_loss_cnt,
  output logic [STATE_W-1:0]    state
);

  localparam int HOLD_W = $clog2(RST_HOLD_CYCLES) + 1;
  localparam int TO_W   = $clog2(LOCK_TIMEOUT) + 1;
  localparam int STB_W  = $clog2(LOCK_STABLE) + 1;

  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);
  localparam logic [TO_W-1:0]    TO_LAST   = TO_W'(LOCK_TIMEOUT - 1);
  localparam logic [STB_W-1:0]   STB_LAST  = STB_W'(LOCK_STABLE - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

  logic lock_sync;

  sync_2ff #(.W(1)) u_lock_sync (
    .clk  (clkin),
    .rst_n(reset_n),
    .d    (pll_lock),
    .q    (lock_sync)
  );

  pll_state_e          state_q, state_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic [STB_W-1:0]    stb_cnt_q, stb_cnt_d;
  logic [RETRY_W-1:0]  retry_cnt_q, retry_cnt_d;
  logic                pll_reset_q, pll_reset_d;
  logic                rst_out_n_q, rst_out_n_d;
  logic                ready_q, ready_d;
  logic                fail_q, fail_d;

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    to_cnt_d    = to_cnt_q;
    stb_cnt_d   = stb_cnt_q;
    retry_cnt_d = retry_cnt_q;

    case (state_q)
      RST_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d = WAIT_LOCK;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      WAIT_LOCK: begin
        to_cnt_d  = to_cnt_q + 1'b1;
        stb_cnt_d = lock_sync ? stb_cnt_q + 1'b1 : '0;
        // Stable completion is tested first so it wins over a same-cycle timeout.
        if (lock_sync && (stb_cnt_q == STB_LAST)) begin
          state_d = RUN;
        end else if (to_cnt_q == TO_LAST) begin
          if (retry_cnt_q < RETRY_MAX) begin
            retry_cnt_d = retry_cnt_q + 1'b1;
            state_d     = RST_HOLD;
          end else begin
            state_d = FAIL;
          end
        end
      end
      RUN: begin
        if (!lock_sync) begin
          retry_cnt_d = '0;
          state_d     = RST_HOLD;
        end
      end
      FAIL: begin
        state_d = FAIL;
      end
      default: begin
        state_d = RST_HOLD;
      end
    endcase

    // restart is a single-cycle request honoured in every state; it restarts the hold window.
    if (restart) begin
      state_d     = RST_HOLD;
      retry_cnt_d = '0;
    end

    if ((state_d != state_q) || restart) begin
      hold_cnt_d = '0;
      to_cnt_d   = '0;
      stb_cnt_d  = '0;
    end

    pll_reset_d = (state_d == RST_HOLD) || (state_d == FAIL);
    rst_out_n_d = (state_d == RUN);
    ready_d     = (state_d == RUN);
    fail_d      = (state_d == FAIL);
  end

  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RST_HOLD;
      hold_cnt_q  <= '0;
      to_cnt_q    <= '0;
      stb_cnt_q   <= '0;
      retry_cnt_q <= '0;
      pll_reset_q <= 1'b1;
      rst_out_n_q <= 1'b0;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      to_cnt_q    <= to_cnt_d;
      stb_cnt_q   <= stb_cnt_d;
      retry_cnt_q <= retry_cnt_d;
      pll_reset_q <= pll_reset_d;
      rst_out_n_q <= rst_out_n_d;
      ready_q     <= ready_d;
      fail_q      <= fail_d;
    end
  end

`ifdef PLL_SEQ_LOSS_CNT_EN
  logic                  lock_lost;
  logic [LOSS_CNT_W-1:0] loss_cnt_q, loss_cnt_d;

  // A loss is counted even when a restart arrives in the same cycle.
  assign lock_lost = (state_q == RUN) && !lock_sync;

  always_comb begin
    loss_cnt_d = loss_cnt_q;
    if (lock_lost) begin
      loss_cnt_d = loss_sat_inc(loss_cnt_q);
    end
  end

  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      loss_cnt_q <= '0;
    end else begin
      loss_cnt_q <= loss_cnt_d;
    end
  end

  assign lock_loss_cnt = loss_cnt_q;
`else
  assign lock_loss_cnt = '0;
`endif

  assign pll_reset = pll_reset_q;
  assign rst_out_n = rst_out_n_q;
  assign ready     = ready_q;
  assign fail      = fail_q;
  assign retry_cnt = retry_cnt_q;
  assign state     = state_q;

endmodule
